vga_linebuf_port: RTL and testbench

- Avalon-MM slave peripheral that replaces the fixed VGA conduit of the game SoC with a parametrised, double-buffered scanline pixel port.
- The Nios II writes packed colour indices for the next line into a back buffer, then commits it. At each end of a visible line the block swaps the back buffer to the front.
- The front buffer is read by drawx and drives color_index to the palette/VGA logic, alongside a CPU-written game_status register.
- It raises an interrupt when the back buffer is free for refill.

---
 rtl/vga_linebuf_pkg.sv | 36 +++
 rtl/vga_linebuf_port_if.sv | 43 ++++
 rtl/vga_linebuf_port_ram.sv | 64 ++++++
 rtl/vga_linebuf_port.sv | 248 ++++++++++++++++++++++++
 tb/tb_vga_linebuf_port.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_linebuf_pkg.sv
// ============================================================================
//  Module      : vga_linebuf_pkg
//  Description : Shared constants for the double-buffered VGA scanline port.
//                Holds the register offsets (counted down from the top of the
//                Avalon word space), the COMMIT read-back bit positions and
//                the pixels-per-word helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_linebuf_pkg;

    // Register word offsets, measured from the top of the address space.
    // The register address is 2**ADDR_W - OFS.
    localparam int REG_STATUS_OFS = 4;
    localparam int REG_COMMIT_OFS = 3;
    localparam int REG_LINE_OFS   = 2;
    localparam int REG_IRQACK_OFS = 1;

    // COMMIT register read-back layout: {28'b0, irq, committed, front_sel, 1'b0}
    localparam int CMT_FRONT_BIT     = 1;
    localparam int CMT_COMMITTED_BIT = 2;
    localparam int CMT_IRQ_BIT       = 3;

    // STATUS bit 31 holds the interrupt enable; IRQACK bit 31 clears underrun.
    localparam int STATUS_IRQEN_BIT  = 31;
    localparam int IRQACK_CLR_BIT    = 31;

    // Number of colour indices packed into one 32-bit Avalon word.
    function automatic int ppw(input int color_w);
        return 32 / color_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_linebuf_port_if.sv
// ============================================================================
//  Module      : vga_linebuf_port_if
//  Description : Avalon-MM slave bus bundle for vga_linebuf_port.
//                master modport: driven by the CPU side (or a testbench).
//                slave  modport: used by the peripheral.
//  Signals     : avl_chipselect, avl_address[ADDR_W], avl_read, avl_write,
//                avl_writedata[32], avl_readdata[32] (readLatency 1)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_linebuf_port_if #(
    parameter int ADDR_W = 9
) ();

    logic                avl_chipselect;
    logic [ADDR_W-1:0]   avl_address;
    logic                avl_read;
    logic                avl_write;
    logic [31:0]         avl_writedata;
    logic [31:0]         avl_readdata;

    modport master (
        output avl_chipselect,
        output avl_address,
        output avl_read,
        output avl_write,
        output avl_writedata,
        input  avl_readdata
    );

    modport slave (
        input  avl_chipselect,
        input  avl_address,
        input  avl_read,
        input  avl_write,
        input  avl_writedata,
        output avl_readdata
    );

endinterface

`default_nettype wire

// File: rtl/vga_linebuf_port_ram.sv
// ============================================================================
//  Module      : linebuf_ram
//  Description : One scanline buffer. Simple dual-port RAM of WORDS x 32 bits;
//                the write side updates COLOR_W-wide lanes of a packed word,
//                dropping lanes whose pixel column lies beyond H_PIX. The read
//                side returns the whole packed word one cycle after the
//                address is presented. Contents are not reset.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write word address
//                i_wdata  - packed write data
//                i_raddr  - read word address
//                o_rdata  - registered packed read data
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module linebuf_ram
    import vga_linebuf_pkg::*;
#(
    parameter int COLOR_W = 8,
    parameter int H_PIX   = 640,
    parameter int WORDS   = 160,
    parameter int WORD_AW = 8
) (
    input  wire logic               clk,
    input  wire logic               i_we,
    input  wire logic [WORD_AW-1:0] i_waddr,
    input  wire logic [31:0]        i_wdata,
    input  wire logic [WORD_AW-1:0] i_raddr,
    output logic      [31:0]        o_rdata
);

    localparam int c_ppw = ppw(COLOR_W);

    logic [31:0]      r_mem [WORDS];
    logic [31:0]      r_rdata;
    logic [c_ppw-1:0] w_lane_en;

    // A lane is written only if its pixel column exists on the line; this
    // keeps the tail of the last word from aliasing past H_PIX.
    always_comb begin
        w_lane_en = '0;
        for (int k = 0; k < c_ppw; k++) begin
            w_lane_en[k] = ((32'(i_waddr) * 32'(c_ppw) + 32'(k)) < 32'(H_PIX));
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < c_ppw; k++) begin
                if (w_lane_en[k]) begin
                    r_mem[i_waddr][k*COLOR_W +: COLOR_W] <= i_wdata[k*COLOR_W +: COLOR_W];
                end
            end
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/vga_linebuf_port.sv
// ============================================================================
//  Module      : vga_linebuf_port
//  Description : Avalon-MM slave providing a double-buffered scanline pixel
//                port. The CPU fills the back buffer with packed colour
//                indices and commits it; at the end of each visible line a
//                committed back buffer is swapped to the front. The front
//                buffer is read by drawx and drives color_index one cycle
//                later. A level interrupt flags that the back buffer is free.
//  Ports       : Clk, Reset      - clock, synchronous active-high reset
//                avl (slave)     - Avalon-MM bus, readLatency 1
//                irq             - back-buffer-free interrupt (level)
//                drawx, drawy    - current pixel column / line
//                color_index     - front-buffer pixel, registered
//                game_status     - CPU-written game state
//  Options     : `define VGA_LINEBUF_UNDERRUN_EN adds a 16-bit saturating
//                underrun counter readable at IRQACK and cleared by writing
//                IRQACK with bit 31 set.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_linebuf_port
    import vga_linebuf_pkg::*;
#(
    parameter int COLOR_W  = 8,
    parameter int H_PIX    = 640,
    parameter int V_LINES  = 525,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int STATUS_W = 2,
    parameter int ADDR_W   = 9
) (
    input  wire logic                Clk,
    input  wire logic                Reset,
    vga_linebuf_port_if.slave        avl,
    output logic                     irq,
    input  wire logic [X_W-1:0]      drawx,
    input  wire logic [Y_W-1:0]      drawy,
    output logic      [COLOR_W-1:0]  color_index,
    output logic      [STATUS_W-1:0] game_status
);

    localparam int c_ppw    = ppw(COLOR_W);
    localparam int c_words  = (H_PIX + c_ppw - 1) / c_ppw;
    localparam int c_waw    = (c_words > 1) ? $clog2(c_words) : 1;
    localparam int c_lane_w = (c_ppw > 1) ? $clog2(c_ppw) : 1;
    localparam int c_top    = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] c_addr_status = ADDR_W'(c_top - REG_STATUS_OFS);
    localparam logic [ADDR_W-1:0] c_addr_commit = ADDR_W'(c_top - REG_COMMIT_OFS);
    localparam logic [ADDR_W-1:0] c_addr_line   = ADDR_W'(c_top - REG_LINE_OFS);
    localparam logic [ADDR_W-1:0] c_addr_irqack = ADDR_W'(c_top - REG_IRQACK_OFS);
    localparam logic [X_W-1:0]    c_last_x      = X_W'(H_PIX - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic                r_front_sel;
    logic                r_committed;
    logic                r_irq;
    logic                r_irq_en;
    logic [STATUS_W-1:0] r_status;
    logic [Y_W-1:0]      r_next_line;
    logic [X_W-1:0]      r_prev_x;
    logic [31:0]         r_readdata;
    logic                r_pix_valid;
    logic                r_pix_sel;
    logic [c_lane_w-1:0] r_pix_lane;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic             w_wr;
    logic             w_rd;
    logic             w_is_buf;
    logic             w_buf_we;
    logic             w_status_wr;
    logic             w_commit_wr;
    logic             w_irqack_wr;
    logic [c_waw-1:0] w_waddr;
    logic [31:0]      w_rd_mux;
    logic [15:0]      w_underrun_rd;

    assign w_wr        = avl.avl_chipselect & avl.avl_write;
    assign w_rd        = avl.avl_chipselect & avl.avl_read;
    assign w_is_buf    = (32'(avl.avl_address) < 32'(c_words));
    assign w_waddr     = avl.avl_address[c_waw-1:0];
    assign w_status_wr = w_wr && (avl.avl_address == c_addr_status);
    assign w_commit_wr = w_wr && (avl.avl_address == c_addr_commit);
    assign w_irqack_wr = w_wr && (avl.avl_address == c_addr_irqack);

    // Once committed, the back buffer belongs to the display until the swap.
    assign w_buf_we    = w_wr & w_is_buf & ~r_committed;

    // ------------------------------------------------------------------
    // Line-end detection and swap decision
    // ------------------------------------------------------------------
    logic           w_line_end;
    logic           w_swap;
    logic [31:0]    w_drawy_inc;
    logic [Y_W-1:0] w_next_line;

    assign w_line_end  = (r_prev_x == c_last_x) && (drawx != c_last_x);
    // A COMMIT landing on the line-end cycle still makes this swap.
    assign w_swap      = w_line_end && (r_committed || w_commit_wr);
    assign w_drawy_inc = 32'(drawy) + 32'd1;
    assign w_next_line = (w_drawy_inc == 32'(V_LINES)) ? '0 : Y_W'(w_drawy_inc);

    // ------------------------------------------------------------------
    // Scanline buffers: buffer index front_sel is displayed, the other
    // is the CPU-writable back buffer.
    // ------------------------------------------------------------------
    logic [c_waw-1:0]    w_raddr;
    logic [c_lane_w-1:0] w_lane;
    logic [31:0]         w_ram_q [2];

    assign w_raddr = c_waw'(32'(drawx) / 32'(c_ppw));
    assign w_lane  = c_lane_w'(32'(drawx) % 32'(c_ppw));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ram
            linebuf_ram #(
                .COLOR_W (COLOR_W),
                .H_PIX   (H_PIX),
                .WORDS   (c_words),
                .WORD_AW (c_waw)
            ) u_ram (
                .clk     (Clk),
                .i_we    (w_buf_we && (r_front_sel != 1'(gi))),
                .i_waddr (w_waddr),
                .i_wdata (avl.avl_writedata),
                .i_raddr (w_raddr),
                .o_rdata (w_ram_q[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read-back mux (samples pre-update state, so a read in a swap cycle
    // returns the pre-swap view)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        if (avl.avl_address == c_addr_status) begin
            w_rd_mux[STATUS_W-1:0]   = r_status;
            w_rd_mux[STATUS_IRQEN_BIT] = r_irq_en;
        end else if (avl.avl_address == c_addr_commit) begin
            w_rd_mux[CMT_IRQ_BIT]       = r_irq;
            w_rd_mux[CMT_COMMITTED_BIT] = r_committed;
            w_rd_mux[CMT_FRONT_BIT]     = r_front_sel;
        end else if (avl.avl_address == c_addr_line) begin
            w_rd_mux[Y_W-1:0] = r_next_line;
        end else if (avl.avl_address == c_addr_irqack) begin
            w_rd_mux[15:0] = w_underrun_rd;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_front_sel <= 1'b0;
            r_committed <= 1'b0;
            r_irq       <= 1'b0;
            r_irq_en    <= 1'b0;
            r_status    <= '0;
            r_next_line <= '0;
            r_prev_x    <= '0;
            r_readdata  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_sel   <= 1'b0;
            r_pix_lane  <= '0;
        end else begin
            r_prev_x <= drawx;

            if (w_status_wr) begin
                r_status <= avl.avl_writedata[STATUS_W-1:0];
                r_irq_en <= avl.avl_writedata[STATUS_IRQEN_BIT];
            end

            if (w_swap) begin
                r_committed <= 1'b0;
                r_front_sel <= ~r_front_sel;
            end else if (w_commit_wr) begin
                r_committed <= 1'b1;
            end

            // Setting wins over an acknowledge in the same cycle.
            if (w_swap && r_irq_en) begin
                r_irq <= 1'b1;
            end else if (w_irqack_wr) begin
                r_irq <= 1'b0;
            end

            if (w_line_end) begin
                r_next_line <= w_next_line;
            end

            r_readdata <= w_rd ? w_rd_mux : 32'd0;

            // Side information that travels with the RAM read so the lane
            // and buffer choice match the word that comes out next cycle.
            r_pix_valid <= (32'(drawx) < 32'(H_PIX));
            r_pix_sel   <= r_front_sel;
            r_pix_lane  <= w_lane;
        end
    end

    // ------------------------------------------------------------------
    // Optional underrun counter
    // ------------------------------------------------------------------
`ifdef VGA_LINEBUF_UNDERRUN_EN
    logic [15:0] r_underrun;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_underrun <= '0;
        end else if (w_irqack_wr && avl.avl_writedata[IRQACK_CLR_BIT]) begin
            r_underrun <= '0;
        end else if (w_line_end && !w_swap && (r_underrun != 16'hFFFF)) begin
            r_underrun <= r_underrun + 16'd1;
        end
    end

    assign w_underrun_rd = r_underrun;
`else
    assign w_underrun_rd = '0;
`endif

    // Write-data bits that no register stores.
    logic w_unused_wdata;
    assign w_unused_wdata = ^avl.avl_writedata;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign avl.avl_readdata = r_readdata;
    assign irq              = r_irq;
    assign game_status      = r_status;
    assign color_index      = r_pix_valid
                            ? w_ram_q[r_pix_sel][r_pix_lane*COLOR_W +: COLOR_W]
                            : '0;

endmodule

`default_nettype wire

// File: tb/tb_vga_linebuf_port.sv
// ============================================================================
//  Module      : tb_vga_linebuf_port
//  Description : Self-checking bench for vga_linebuf_port. A pixel-array
//                model of both scanline buffers and the register file tracks
//                the expected outputs every cycle; directed scenarios add
//                literal expectations, followed by randomized traffic.
//  Options     : honours VGA_LINEBUF_UNDERRUN_EN for the underrun register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_linebuf_port;

    localparam int H     = 640;
    localparam int V     = 525;
    localparam int T     = 512;
    localparam int WORDS = 160;
`ifdef VGA_LINEBUF_UNDERRUN_EN
    localparam bit UND = 1'b1;
`else
    localparam bit UND = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic       irq;
    logic [9:0] drawx;
    logic [9:0] drawy;
    logic [7:0] color_index;
    logic [1:0] game_status;

    always #5 Clk = ~Clk;

    vga_linebuf_port_if #(.ADDR_W(9)) bus ();

    vga_linebuf_port dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .avl         (bus),
        .irq         (irq),
        .drawx       (drawx),
        .drawy       (drawy),
        .color_index (color_index),
        .game_status (game_status)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: two pixel arrays plus the register file.
    // ------------------------------------------------------------------
    logic [7:0]  pix   [2][H];
    bit          known [2][H];
    int          m_front, m_committed, m_irq, m_irq_en, m_status;
    int          m_next_line, m_underrun, m_prev_x;
    logic [31:0] exp_rd;
    bit          exp_rd_v;
    logic [7:0]  exp_ci;
    bit          exp_ci_v;
    int          exp_irq, exp_status;
    bit          model_on = 1'b0;

    always @(posedge Clk) begin
        int          a;
        logic [31:0] d;
        bit          wr_, rd_, le, cw, ack, sw;
        logic [31:0] rv;
        a = int'(bus.avl_address);
        d = bus.avl_writedata;
        if (Reset) begin
            m_front = 0; m_committed = 0; m_irq = 0; m_irq_en = 0; m_status = 0;
            m_next_line = 0; m_underrun = 0; m_prev_x = 0;
            exp_rd = 0; exp_rd_v = 1; exp_ci = 0; exp_ci_v = 1;
        end else begin
            wr_ = bus.avl_chipselect && bus.avl_write;
            rd_ = bus.avl_chipselect && bus.avl_read;
            rv  = 0;
            if (a == T-4) begin
                rv[31] = m_irq_en[0]; rv[1:0] = m_status[1:0];
            end else if (a == T-3) begin
                rv = 32'(m_irq*8 + m_committed*4 + m_front*2);
            end else if (a == T-2) begin
                rv = 32'(m_next_line);
            end else if (a == T-1) begin
                rv = UND ? 32'(m_underrun) : 32'd0;
            end
            exp_rd_v = rd_;
            exp_rd   = rv;

            if (int'(drawx) >= H) begin
                exp_ci = 0; exp_ci_v = 1;
            end else begin
                exp_ci = pix[m_front][drawx]; exp_ci_v = known[m_front][drawx];
            end

            le  = (m_prev_x == H-1) && (int'(drawx) != H-1);
            cw  = wr_ && (a == T-3);
            ack = wr_ && (a == T-1);
            sw  = le && (m_committed != 0 || cw);

            if (wr_ && a < WORDS && m_committed == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (a*4 + k < H) begin
                        pix[1-m_front][a*4+k]   = d[8*k +: 8];
                        known[1-m_front][a*4+k] = 1'b1;
                    end
                end
            end
            if (sw && m_irq_en != 0) m_irq = 1;
            else if (ack)            m_irq = 0;
            if (UND) begin
                if (ack && d[31])                        m_underrun = 0;
                else if (le && !sw && m_underrun < 65535) m_underrun++;
            end
            if (wr_ && a == T-4) begin
                m_status = int'(d[1:0]); m_irq_en = int'(d[31]);
            end
            if (sw)      m_committed = 0;
            else if (cw) m_committed = 1;
            if (sw) m_front = 1 - m_front;
            if (le) m_next_line = (int'(drawy) + 1 == V) ? 0 : int'(drawy) + 1;
            m_prev_x = int'(drawx);
        end
        exp_irq    = m_irq;
        exp_status = m_status;
        model_on   = 1'b1;
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge Clk) begin
        if (model_on) begin
            chk("irq", 32'(irq), 32'(exp_irq));
            chk("game_status", 32'(game_status), 32'(exp_status));
            if (exp_rd_v) chk("readdata", bus.avl_readdata, exp_rd);
            if (exp_ci_v) chk("color_index", 32'(color_index), 32'(exp_ci));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic bus_idle();
        bus.avl_chipselect = 1'b0;
        bus.avl_read       = 1'b0;
        bus.avl_write      = 1'b0;
    endtask

    task automatic bus_op(input int op, input int a, input logic [31:0] d);
        bus.avl_chipselect = (op != 0);
        bus.avl_write      = (op == 1);
        bus.avl_read       = (op == 2);
        bus.avl_address    = 9'(a);
        bus.avl_writedata  = d;
    endtask

    task automatic av_write(input int a, input logic [31:0] d);
        bus_op(1, a, d);
        @(negedge Clk);
        bus_idle();
    endtask

    task automatic av_read(input int a, output logic [31:0] d);
        bus_op(2, a, 32'd0);
        @(negedge Clk);
        bus_idle();
        d = bus.avl_readdata;
    endtask

    // Full visible line on row y, then move to column 640 with an optional
    // bus operation landing exactly on the line-end cycle.
    task automatic sweep(input int y, input int op, input int a, input logic [31:0] wd,
                         output logic [31:0] rd);
        for (int x = 0; x < H; x++) begin
            drawx = 10'(x); drawy = 10'(y);
            @(negedge Clk);
        end
        drawx = 10'(H);
        bus_op(op, a, wd);
        @(negedge Clk);
        bus_idle();
        rd = bus.avl_readdata;
    endtask

    task automatic show_x(input int x);
        drawx = 10'(x);
        @(negedge Clk);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] rd;
        logic [7:0]  e4 [4];
        e4 = '{8'h40, 8'h30, 8'h20, 8'h10};

        Reset = 1'b1;
        bus_idle();
        bus.avl_address   = '0;
        bus.avl_writedata = '0;
        drawx = '0;
        drawy = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // 1: reset state, STATUS write
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_status", 32'(game_status), 32'd0);
        chk("rst_color", 32'(color_index), 32'd0);
        av_write(T-4, 32'h8000_0002);
        chk("status_out", 32'(game_status), 32'd2);
        av_read(T-4, rd);
        chk("status_rd", rd, 32'h8000_0002);

        // 2: fill, commit, swap at 639 -> 640
        for (int w = 0; w < WORDS; w++) av_write(w, 32'h0302_0100 + 32'h0404_0404 * 32'(w));
        av_write(T-3, 32'd0);
        sweep(0, 0, 0, 0, rd);
        chk("swap_irq", 32'(irq), 32'd1);
        av_read(T-3, rd);
        chk("commit_rd_after_swap", rd, 32'hA);
        av_read(T-2, rd);
        chk("line_rd", rd, 32'd1);
        show_x(5);
        chk("pix5", 32'(color_index), 32'h05);

        // 3: underrun line
        sweep(1, 0, 0, 0, rd);
        av_read(T-3, rd);
        chk("no_swap_commit_rd", rd, 32'hA);
        show_x(5);
        chk("pix5_repeat", 32'(color_index), 32'h05);
        av_read(T-1, rd);
        chk("underrun_rd", rd, UND ? 32'd1 : 32'd0);
        av_write(T-1, 32'h8000_0000);
        av_read(T-1, rd);
        chk("underrun_clr", rd, 32'd0);
        av_read(T-3, rd);
        chk("irq_ack_commit_rd", rd, 32'h2);

        // 4: locked buffer ignores writes; read during swap is pre-swap
        for (int w = 0; w < WORDS; w++) av_write(w, 32'h1020_3040 + 32'h0101_0101 * 32'(w));
        av_write(T-3, 32'd0);
        av_write(0, 32'hFFFF_FFFF);
        sweep(2, 2, T-3, 0, rd);
        chk("commit_rd_in_swap", rd, 32'h6);
        for (int x = 0; x < 4; x++) begin
            show_x(x);
            chk("locked_pix", 32'(color_index), 32'(e4[x]));
        end
        av_write(T-1, 32'd0);

        // 5: COMMIT on the line-end cycle of the last line
        sweep(V-1, 1, T-3, 0, rd);
        av_read(T-2, rd);
        chk("line_wrap", rd, 32'd0);
        av_read(T-3, rd);
        chk("late_commit_swap", rd, 32'hA);
        show_x(5);
        chk("pix5_late", 32'(color_index), 32'h05);

        // 6: IRQACK racing a swap
        av_write(T-1, 32'd0);
        chk("irq_cleared", 32'(irq), 32'd0);
        av_write(T-3, 32'd0);
        sweep(0, 1, T-1, 0, rd);
        chk("irq_set_wins", 32'(irq), 32'd1);
        av_write(T-1, 32'd0);
        chk("irq_ack_alone", 32'(irq), 32'd0);
        show_x(700);
        chk("pix_offscreen", 32'(color_index), 32'd0);

        // Randomized traffic
        for (int line = 0; line < 25; line++) begin
            int y;
            int x;
            y = ($urandom_range(0, 4) == 0) ? V-1 : int'($urandom_range(0, V-1));
            x = int'($urandom_range(0, H-1));
            while (x <= H + 2) begin
                int r;
                int s;
                int a;
                r = int'($urandom_range(0, 39));
                drawx = (r == 0) ? 10'($urandom_range(H + 3, 1023)) : 10'(x);
                drawy = 10'(y);
                s = int'($urandom_range(0, 9));
                if (s < 4)       a = int'($urandom_range(0, WORDS-1));
                else if (s == 4) a = int'($urandom_range(WORDS, T-5));
                else             a = int'($urandom_range(T-4, T-1));
                case ($urandom_range(0, 5))
                    0:       bus_op(1, a, $urandom);
                    1:       bus_op(2, a, 32'd0);
                    default: bus_idle();
                endcase
                @(negedge Clk);
                bus_idle();
                if (r > 4) x++;
            end
        end

        bus_idle();
        repeat (3) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
